spi_txn_arbiter: RTL

- Shares one SPI register wrapper and its SPI master among N_REQ requesters.
- Each requester presents a full transaction: mode, SCK speed, word length, IFG/CS-SCK/SCK-CS timing and MOSI word.
- Round-robin arbitration. The granted configuration is held stable for the whole transfer.
- Sequences start/busy through the wrapper's registered interface and returns the MISO word to the winner.
- Sits between bus-side requesters and the SPI wrapper instance.

---
 rtl/spi_txn_arbiter.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter that shares one SPI register wrapper among N_REQ requesters.
// Define SPI_ARB_TIMEOUT_EN to add a start-to-busy watchdog (START_TIMEOUT cycles).
module spi_txn_arbiter #(
    parameter int unsigned N_REQ         = 2,
    parameter int unsigned GW            = 3,
    parameter int unsigned START_TIMEOUT = 64
) (
    input  logic                GCLK,
    input  logic                RST,
    input  logic [N_REQ-1:0]    req_valid,
    output logic [N_REQ-1:0]    req_ready,
    input  logic [N_REQ*30-1:0] req_cfg,
    input  logic [N_REQ*32-1:0] req_mosi,
    output logic [N_REQ-1:0]    rsp_valid,
    output logic [31:0]         rsp_data,
    output logic                rsp_err,
    output logic [GW-1:0]       cs_sel,
    output logic                start_out,
    output logic [1:0]          spi_mode_out,
    output logic [1:0]          sck_speed_out,
    output logic [1:0]          word_len_out,
    output logic [7:0]          IFG_out,
    output logic [7:0]          CS_SCK_out,
    output logic [7:0]          SCK_CS_out,
    output logic [31:0]         mosi_data_out,
    input  logic                busy_in,
    input  logic [31:0]         miso_data_in
);

    if (N_REQ < 2 || N_REQ > 8 || (1 << GW) < N_REQ || START_TIMEOUT < 1) begin : g_bad_params
        $error("spi_txn_arbiter: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_SETTLE,
        S_RESP
    } state_e;

    state_e            state_q;
    logic [GW-1:0]     ptr_q;
    logic [GW-1:0]     cs_q;
    logic [29:0]       cfg_q;
    logic [31:0]       mosi_q;
    logic              start_q;
    logic [N_REQ-1:0]  rsp_valid_q;
    logic [31:0]       rsp_data_q;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int unsigned TW = $clog2(START_TIMEOUT + 1);
    logic [TW-1:0]     tmo_q;
    logic              rsp_err_q;
`endif

    logic              gnt_vld;
    logic [GW-1:0]     gnt_idx;
    logic [GW-1:0]     ptr_d;
    logic [29:0]       gnt_cfg;
    logic [31:0]       gnt_mosi;
    logic [N_REQ-1:0]  own_oh;

    // Two passes: first requester at or above the pointer, else the lowest one (wrap).
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!gnt_vld && req_valid[i] && (i >= 32'(ptr_q))) begin
                gnt_vld = 1'b1;
                gnt_idx = GW'(i);
            end
        end
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!gnt_vld && req_valid[i]) begin
                gnt_vld = 1'b1;
                gnt_idx = GW'(i);
            end
        end
    end

    always_comb begin
        gnt_cfg  = '0;
        gnt_mosi = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (gnt_idx == GW'(i)) begin
                gnt_cfg  = req_cfg[30*i +: 30];
                gnt_mosi = req_mosi[32*i +: 32];
            end
        end
        ptr_d = (32'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + GW'(1);
    end

    // req_ready is the combinational grant so it pulses in the same cycle the config is taken.
    always_comb begin
        req_ready = '0;
        own_oh    = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            req_ready[i] = RST && (state_q == S_IDLE) && gnt_vld && (gnt_idx == GW'(i));
            own_oh[i]    = (cs_q == GW'(i));
        end
    end

    always_ff @(posedge GCLK or negedge RST) begin
        if (!RST) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            cs_q        <= '0;
            cfg_q       <= '0;
            mosi_q      <= '0;
            start_q     <= 1'b0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
            tmo_q       <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (gnt_vld) begin
                        cs_q    <= gnt_idx;
                        cfg_q   <= gnt_cfg;
                        mosi_q  <= gnt_mosi;
                        ptr_q   <= ptr_d;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    start_q <= 1'b1;
                    state_q <= S_START;
                end
                S_START: begin
                    start_q <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
                    tmo_q   <= '0;
`endif
                    state_q <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (busy_in) begin
                        state_q <= S_WAIT_DONE;
`ifdef SPI_ARB_TIMEOUT_EN
                    end else if (tmo_q == TW'(START_TIMEOUT - 1)) begin
                        rsp_valid_q <= own_oh;
                        rsp_err_q   <= 1'b1;
                        state_q     <= S_RESP;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
`endif
                    end
                end
                S_WAIT_DONE: begin
                    if (!busy_in) begin
                        state_q <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    rsp_data_q  <= miso_data_in;
                    rsp_valid_q <= own_oh;
                    state_q     <= S_RESP;
                end
                S_RESP: begin
                    rsp_valid_q <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
                    rsp_err_q   <= 1'b0;
`endif
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign {spi_mode_out, sck_speed_out, word_len_out, IFG_out, CS_SCK_out, SCK_CS_out} = cfg_q;
    assign mosi_data_out = mosi_q;
    assign cs_sel        = cs_q;
    assign start_out     = start_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
`ifdef SPI_ARB_TIMEOUT_EN
    assign rsp_err       = rsp_err_q;
`else
    assign rsp_err       = 1'b0;
`endif

endmodule
